// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Drives the modular ADC core's Avalon-ST command sink and consumes its
// response source. A fixed list of channels is scanned round-robin with one
// single-beat command in flight at a time. 2**AVG_LOG2 matching conversions are
// summed per list entry and one averaged sample is presented per entry visit.
//
// Ports
//   clock_clk, reset_sink_reset_n : system clock, async active-low reset
//   enable                        : 1 = scan, 0 = stop after current conversion
//   command_*                     : Avalon-ST command source toward the ADC core
//   response_*                    : Avalon-ST response sink (no backpressure)
//   sample_*                      : averaged sample, sample_valid is a 1-clk pulse
//   err_timeout, err_mismatch     : 1-clk error pulses
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int unsigned         NUM_CH   = 4,
  parameter logic [5*NUM_CH-1:0] CH_LIST  = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int unsigned         AVG_LOG2 = 2,
  parameter int unsigned         TIMEOUT  = 1023
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset_n,
  input  logic        enable,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  output logic        sample_valid,
  output logic [2:0]  sample_index,
  output logic [4:0]  sample_channel,
  output logic [11:0] sample_data,
  output logic        err_timeout,
  output logic        err_mismatch
);

  // Accumulator is wide enough for 2**AVG_LOG2 full-scale 12-bit values.
  localparam int unsigned     ACC_W    = 12 + AVG_LOG2;
  localparam int unsigned     CNT_W    = AVG_LOG2 + 1;
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              sample_valid_q, sample_valid_d;
  logic [2:0]        sample_index_q, sample_index_d;
  logic [4:0]        sample_channel_q, sample_channel_d;
  logic [11:0]       sample_data_q, sample_data_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_mismatch_q, err_mismatch_d;

  logic [4:0]        cur_ch;
  logic [ACC_W-1:0]  acc_sum;
  logic              rsp_match;
  logic              rsp_mismatch;

  // Response framing carries no information for single-beat responses.
  logic unused_rsp_framing;
  assign unused_rsp_framing = response_startofpacket ^ response_endofpacket;

  assign cur_ch       = CH_LIST[5*int'(idx_q) +: 5];
  assign acc_sum      = acc_q + ACC_W'(response_data);
  assign rsp_match    = response_valid && (response_channel == cur_ch);
  assign rsp_mismatch = response_valid && (response_channel != cur_ch);

  always_comb begin
    // NOTE: every _d signal gets its default before the case so no path
    // through the decode leaves a value unassigned and infers a latch.
    state_d          = state_q;
    idx_d            = idx_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
    tmo_d            = tmo_q;
    sample_valid_d   = 1'b0;
    sample_index_d   = sample_index_q;
    sample_channel_d = sample_channel_q;
    sample_data_d    = sample_data_q;
    err_timeout_d    = 1'b0;
    err_mismatch_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A partial average left by a stop is discarded here.
        acc_d = '0;
        cnt_d = '0;
        if (enable) state_d = ST_CMD;
      end

      ST_CMD: begin
        // Command is never retracted: enable is ignored until accepted.
        if (command_ready) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end
      end

      ST_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (rsp_match) begin
          // A matching response wins over a simultaneous timeout.
          if (cnt_q == CNT_LAST) begin
            sample_valid_d   = 1'b1;
            sample_index_d   = idx_q;
            sample_channel_d = cur_ch;
            sample_data_d    = 12'(acc_sum >> AVG_LOG2);
            acc_d            = '0;
            cnt_d            = '0;
            idx_d            = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
          state_d = enable ? ST_CMD : ST_IDLE;
        end else begin
          if (rsp_mismatch) err_mismatch_d = 1'b1;
          // Lost response: re-issue the same entry, keeping the partial sum.
          if (tmo_q == TMO_MAX) begin
            err_timeout_d = 1'b1;
            state_d       = ST_CMD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      acc_q            <= '0;
      cnt_q            <= '0;
      tmo_q            <= '0;
      sample_valid_q   <= 1'b0;
      sample_index_q   <= '0;
      sample_channel_q <= '0;
      sample_data_q    <= '0;
      err_timeout_q    <= 1'b0;
      err_mismatch_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q          <= state_d;
      idx_q            <= idx_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      tmo_q            <= tmo_d;
      sample_valid_q   <= sample_valid_d;
      sample_index_q   <= sample_index_d;
      sample_channel_q <= sample_channel_d;
      sample_data_q    <= sample_data_d;
      err_timeout_q    <= err_timeout_d;
      err_mismatch_q   <= err_mismatch_d;
    end
  end

  assign command_valid         = (state_q == ST_CMD);
  // Channel is forced to 0 when idle so all outputs read 0 out of reset.
  assign command_channel       = command_valid ? cur_ch : 5'd0;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;

  assign sample_valid   = sample_valid_q;
  assign sample_index   = sample_index_q;
  assign sample_channel = sample_channel_q;
  assign sample_data    = sample_data_q;
  assign err_timeout    = err_timeout_q;
  assign err_mismatch   = err_mismatch_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Two instances share the ADC-core-side inputs: u_avg4 (defaults, 4-entry
// list 1,2,3,4, average of 4) and u_raw (3-entry list 9,0,30, AVG_LOG2=0).
// The idle instance ignores the shared traffic. A reference model tracks the
// list position and the values the core returned per entry, and computes each
// expected sample as plain sum/N.
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

  typedef struct packed {
    logic [2:0]  idx;
    logic [4:0]  ch;
    logic [11:0] data;
  } smp_t;

  logic        clk;
  logic        rst_n;
  logic        enable, enable2;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        rsp_sop, rsp_eop;

  logic        cmd_valid0, cmd_sop0, cmd_eop0, smp_valid0, err_tmo0, err_mm0;
  logic [4:0]  cmd_ch0, smp_ch0;
  logic [2:0]  smp_idx0;
  logic [11:0] smp_data0;
  logic        cmd_valid1, cmd_sop1, cmd_eop1, smp_valid1, err_tmo1, err_mm1;
  logic [4:0]  cmd_ch1, smp_ch1;
  logic [2:0]  smp_idx1;
  logic [11:0] smp_data1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_tmo    = 0;
  int n_mm     = 0;

  // Which instance the stimulus tasks talk to.
  int sel = 0;

  // Reference model state.
  int   exp_idx[2];
  int   part_sum[2];
  int   part_cnt[2];
  smp_t exp0_q[$];
  smp_t exp1_q[$];

  adc_scan_sequencer u_avg4 (
    .clock_clk(clk), .reset_sink_reset_n(rst_n), .enable(enable),
    .command_valid(cmd_valid0), .command_channel(cmd_ch0),
    .command_startofpacket(cmd_sop0), .command_endofpacket(cmd_eop0),
    .command_ready(command_ready),
    .response_valid(response_valid), .response_channel(response_channel),
    .response_data(response_data), .response_startofpacket(rsp_sop),
    .response_endofpacket(rsp_eop),
    .sample_valid(smp_valid0), .sample_index(smp_idx0), .sample_channel(smp_ch0),
    .sample_data(smp_data0), .err_timeout(err_tmo0), .err_mismatch(err_mm0)
  );

  adc_scan_sequencer #(
    .NUM_CH(3), .CH_LIST({5'd30, 5'd0, 5'd9}), .AVG_LOG2(0), .TIMEOUT(1023)
  ) u_raw (
    .clock_clk(clk), .reset_sink_reset_n(rst_n), .enable(enable2),
    .command_valid(cmd_valid1), .command_channel(cmd_ch1),
    .command_startofpacket(cmd_sop1), .command_endofpacket(cmd_eop1),
    .command_ready(command_ready),
    .response_valid(response_valid), .response_channel(response_channel),
    .response_data(response_data), .response_startofpacket(rsp_sop),
    .response_endofpacket(rsp_eop),
    .sample_valid(smp_valid1), .sample_index(smp_idx1), .sample_channel(smp_ch1),
    .sample_data(smp_data1), .err_timeout(err_tmo1), .err_mismatch(err_mm1)
  );

  logic       c_valid;
  logic [4:0] c_ch;
  logic [1:0] c_frame;
  assign c_valid = (sel == 1) ? cmd_valid1 : cmd_valid0;
  assign c_ch    = (sel == 1) ? cmd_ch1 : cmd_ch0;
  assign c_frame = (sel == 1) ? {cmd_sop1, cmd_eop1} : {cmd_sop0, cmd_eop0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [4:0] list_ch(input int s, input int i);
    int l0[4] = '{1, 2, 3, 4};
    int l1[3] = '{9, 0, 30};
    return (s == 0) ? 5'(l0[i]) : 5'(l1[i]);
  endfunction

  function automatic void model_accept(input logic [11:0] data);
    int   n    = (sel == 0) ? 4 : 1;
    int   nent = (sel == 0) ? 4 : 3;
    smp_t e;
    part_sum[sel] += int'(data);
    part_cnt[sel]++;
    if (part_cnt[sel] == n) begin
      e.idx  = 3'(exp_idx[sel]);
      e.ch   = list_ch(sel, exp_idx[sel]);
      e.data = 12'(part_sum[sel] / n);
      if (sel == 0) exp0_q.push_back(e);
      else          exp1_q.push_back(e);
      part_sum[sel] = 0;
      part_cnt[sel] = 0;
      exp_idx[sel]  = (exp_idx[sel] + 1) % nent;
    end
  endfunction

  function automatic void model_abandon();
    part_sum[sel] = 0;
    part_cnt[sel] = 0;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_idx[s]  = 0;
      part_sum[s] = 0;
      part_cnt[s] = 0;
    end
  endfunction

  // ---------------- sample scoreboard / error monitor ----------------
  always @(negedge clk) begin
    smp_t g, e;
    if (smp_valid0) begin
      g = {smp_idx0, smp_ch0, smp_data0};
      n_checks++;
      if (exp0_q.size() == 0) begin
        $display("FAIL sample0_unexpected got idx=%0d ch=%0d data=%0d, none required",
                 g.idx, g.ch, g.data);
      end else begin
        e = exp0_q.pop_front();
        if (g !== e)
          $display("FAIL sample0 got idx=%0d ch=%0d data=%0d, required idx=%0d ch=%0d data=%0d",
                   g.idx, g.ch, g.data, e.idx, e.ch, e.data);
        else n_pass++;
      end
    end
    if (smp_valid1) begin
      g = {smp_idx1, smp_ch1, smp_data1};
      n_checks++;
      if (exp1_q.size() == 0) begin
        $display("FAIL sample1_unexpected got idx=%0d ch=%0d data=%0d, none required",
                 g.idx, g.ch, g.data);
      end else begin
        e = exp1_q.pop_front();
        if (g !== e)
          $display("FAIL sample1 got idx=%0d ch=%0d data=%0d, required idx=%0d ch=%0d data=%0d",
                   g.idx, g.ch, g.data, e.idx, e.ch, e.data);
        else n_pass++;
      end
    end
    if (err_tmo0 || err_tmo1) n_tmo++;
    if (err_mm0 || err_mm1)   n_mm++;
  end

  // ---------------- ADC core model ----------------
  task automatic accept_cmd(input int rdy_dly, input bit drop_en, output logic [4:0] ch);
    int t = 0;
    @(negedge clk);
    while (!c_valid && t < 64) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!c_valid)
      $display("FAIL cmd_wait no command_valid within %0d clocks", t);
    else if (c_ch !== list_ch(sel, exp_idx[sel]) || c_frame !== 2'b11)
      $display("FAIL cmd_channel got ch=%0d sop/eop=%b, required ch=%0d sop/eop=11",
               c_ch, c_frame, list_ch(sel, exp_idx[sel]));
    else n_pass++;
    ch = c_ch;
    if (drop_en) begin
      if (sel == 0) enable = 1'b0;
      else          enable2 = 1'b0;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      n_checks++;
      if (c_valid !== 1'b1 || c_ch !== ch)
        $display("FAIL cmd_stable cycle %0d got valid=%b ch=%0d, required valid=1 ch=%0d",
                 i, c_valid, c_ch, ch);
      else n_pass++;
    end
    command_ready = 1'b1;
    @(posedge clk);
    #1 command_ready = 1'b0;
  endtask

  task automatic respond(input int lat, input logic [4:0] ch, input logic [11:0] data);
    repeat (lat) @(posedge clk);
    #1;
    response_valid   = 1'b1;
    response_channel = ch;
    response_data    = data;
    rsp_sop          = 1'b1;
    rsp_eop          = 1'b1;
    @(posedge clk);
    #1;
    response_valid = 1'b0;
    rsp_sop        = 1'b0;
    rsp_eop        = 1'b0;
  endtask

  task automatic conv(input logic [11:0] data);
    logic [4:0] ch;
    accept_cmd($urandom_range(0, 2), 1'b0, ch);
    respond($urandom_range(0, 5), ch, data);
    model_accept(data);
  endtask

  task automatic settle_and_check_drained(input string name);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0)
      $display("FAIL %s_pending got %0d/%0d samples still outstanding, required 0/0",
               name, exp0_q.size(), exp1_q.size());
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; command_ready = 1'b0;
    response_valid = 1'b0; response_channel = '0; response_data = '0;
    rsp_sop = 1'b0; rsp_eop = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_valid0, cmd_ch0, cmd_sop0, cmd_eop0} !== 8'd0)
      $display("FAIL reset_cmd got %b, required 0", {cmd_valid0, cmd_ch0, cmd_sop0, cmd_eop0});
    else n_pass++;
    n_checks++;
    if ({smp_valid0, smp_idx0, smp_ch0, smp_data0} !== 21'd0)
      $display("FAIL reset_sample got %h, required 0", {smp_valid0, smp_idx0, smp_ch0, smp_data0});
    else n_pass++;
    n_checks++;
    if ({err_tmo0, err_mm0} !== 2'b00)
      $display("FAIL reset_err got %b, required 00", {err_tmo0, err_mm0});
    else n_pass++;
    n_checks++;
    if ({cmd_valid1, cmd_ch1, smp_valid1, smp_idx1, smp_ch1, smp_data1, err_tmo1, err_mm1} !== 29'd0)
      $display("FAIL reset_raw got %h, required 0",
               {cmd_valid1, cmd_ch1, smp_valid1, smp_idx1, smp_ch1, smp_data1, err_tmo1, err_mm1});
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cmd_valid0 !== 1'b0)
      $display("FAIL idle_disabled got command_valid=%b, required 0", cmd_valid0);
    else n_pass++;
  endtask

  task automatic test_scan;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) conv(12'd100);
    for (int i = 0; i < 16; i++) conv(12'($urandom_range(0, 4095)));
    settle_and_check_drained("scan");
  endtask

  task automatic test_average;
    int vals[4] = '{10, 11, 12, 14};
    logic [4:0] ch;
    for (int i = 0; i < 4; i++) begin
      accept_cmd(0, 1'b0, ch);
      respond(1, ch, 12'(vals[i]));
      model_accept(12'(vals[i]));
    end
    // One clock after the final matching response edge.
    n_checks++;
    if (smp_valid0 !== 1'b1 || smp_data0 !== 12'd11 || smp_ch0 !== 5'd1 || smp_idx0 !== 3'd0)
      $display("FAIL avg_fixed got valid=%b data=%0d ch=%0d idx=%0d, required 1/11/1/0",
               smp_valid0, smp_data0, smp_ch0, smp_idx0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (smp_valid0 !== 1'b0 || smp_data0 !== 12'd11)
      $display("FAIL avg_hold got valid=%b data=%0d, required 0/11", smp_valid0, smp_data0);
    else n_pass++;
    settle_and_check_drained("average");
  endtask

  task automatic test_ready_hold;
    int tmo0 = n_tmo;
    logic [4:0] ch;
    logic [11:0] d;
    d = 12'($urandom_range(0, 4095));
    accept_cmd(20, 1'b0, ch);
    respond(2, ch, d);
    model_accept(d);
    while (part_cnt[0] != 0) conv(12'($urandom_range(0, 4095)));
    n_checks++;
    if (n_tmo != tmo0)
      $display("FAIL ready_hold_tmo got %0d timeouts, required 0", n_tmo - tmo0);
    else n_pass++;
    settle_and_check_drained("ready_hold");
  endtask

  task automatic test_timeout;
    logic [4:0] ch;
    int cyc = 0;
    bit seen = 0;
    conv(12'($urandom_range(0, 4095)));
    accept_cmd(0, 1'b0, ch);
    while (cyc < 1100 && !seen) begin
      @(negedge clk);
      cyc++;
      seen = err_tmo0;
    end
    n_checks++;
    if (!seen || cyc - 1 != 1024)
      $display("FAIL timeout_clocks got seen=%0d wait_clocks=%0d, required 1/1024", seen, cyc - 1);
    else n_pass++;
    n_checks++;
    if (cmd_valid0 !== 1'b1 || cmd_ch0 !== ch)
      $display("FAIL timeout_reissue got valid=%b ch=%0d, required 1/%0d", cmd_valid0, cmd_ch0, ch);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err_tmo0 !== 1'b0)
      $display("FAIL timeout_pulse got err_timeout=%b one clock later, required 0", err_tmo0);
    else n_pass++;
    while (part_cnt[0] != 0) conv(12'($urandom_range(0, 4095)));
    settle_and_check_drained("timeout");
  endtask

  task automatic test_mismatch;
    logic [4:0] ch, bad;
    logic [11:0] d;
    conv(12'($urandom_range(0, 4095)));
    accept_cmd(0, 1'b0, ch);
    bad = ch + 5'($urandom_range(1, 31));
    respond(1, bad, 12'($urandom_range(0, 4095)));
    n_checks++;
    if (err_mm0 !== 1'b1 || cmd_valid0 !== 1'b0)
      $display("FAIL mismatch_pulse got err=%b cmd_valid=%b, required 1/0", err_mm0, cmd_valid0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (err_mm0 !== 1'b0 || cmd_valid0 !== 1'b0)
      $display("FAIL mismatch_wait got err=%b cmd_valid=%b, required 0/0", err_mm0, cmd_valid0);
    else n_pass++;
    d = 12'($urandom_range(0, 4095));
    respond(0, ch, d);
    model_accept(d);
    while (part_cnt[0] != 0) conv(12'($urandom_range(0, 4095)));
    settle_and_check_drained("mismatch");
  endtask

  task automatic test_enable_drop;
    logic [4:0] ch;
    int mm0;
    conv(12'($urandom_range(0, 4095)));
    conv(12'($urandom_range(0, 4095)));
    accept_cmd(0, 1'b0, ch);
    enable = 1'b0;
    respond(2, ch, 12'($urandom_range(0, 4095)));
    model_abandon();
    mm0 = n_mm;
    respond(1, 5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (cmd_valid0 !== 1'b0)
        $display("FAIL drop_idle cycle %0d got command_valid=%b, required 0", i, cmd_valid0);
      else n_pass++;
    end
    n_checks++;
    if (n_mm != mm0)
      $display("FAIL idle_response got %0d mismatch pulses, required 0", n_mm - mm0);
    else n_pass++;
    // Drop enable while the command is pending: it must stay valid until taken.
    enable = 1'b1;
    accept_cmd(3, 1'b1, ch);
    respond(0, ch, 12'($urandom_range(0, 4095)));
    model_abandon();
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_valid0 !== 1'b0)
      $display("FAIL drop_in_cmd got command_valid=%b, required 0", cmd_valid0);
    else n_pass++;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) conv(12'($urandom_range(0, 4095)));
    settle_and_check_drained("enable_drop");
  endtask

  task automatic test_reset_mid_wait;
    logic [4:0] ch;
    conv(12'($urandom_range(1, 4095)));
    accept_cmd(0, 1'b0, ch);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_valid0, cmd_ch0, cmd_sop0, cmd_eop0, smp_valid0, smp_idx0, smp_ch0,
         smp_data0, err_tmo0, err_mm0} !== 31'd0)
      $display("FAIL async_reset got %h, required 0",
               {cmd_valid0, cmd_ch0, cmd_sop0, cmd_eop0, smp_valid0, smp_idx0, smp_ch0,
                smp_data0, err_tmo0, err_mm0});
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) conv(12'($urandom_range(0, 4095)));
    settle_and_check_drained("reset_mid_wait");
  endtask

  task automatic test_raw_passthrough;
    logic [4:0] ch;
    // Park the averaging instance in IDLE so it ignores the shared bus.
    accept_cmd(0, 1'b1, ch);
    respond(0, ch, 12'($urandom_range(0, 4095)));
    model_abandon();
    repeat (2) @(negedge clk);
    sel = 1;
    enable2 = 1'b1;
    for (int i = 0; i < 7; i++) conv(12'($urandom_range(0, 4095)));
    n_checks++;
    if (cmd_valid0 !== 1'b0)
      $display("FAIL raw_other_idle got command_valid=%b, required 0", cmd_valid0);
    else n_pass++;
    settle_and_check_drained("raw");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_average();
    test_ready_hold();
    test_timeout();
    test_mismatch();
    test_enable_drop();
    test_reset_mid_wait();
    test_raw_passthrough();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
